mem_arbiter: RTL

Shares one single-ported backing memory between the instruction-fetch port (I) and the load/store port (D) of the 5-stage core. It accepts one transaction at a time and drives the memory with registered outputs. It counts a fixed memory latency and returns read data or a write acknowledge to the owning port. The default policy is fixed D-over-I priority, with a starvation guard for I.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_sel.sv | 80 ++++++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default timing constants for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int unsigned LATENCY_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selection between fetch (I) and load/store (D) ports.
// Default: fixed D>I priority with starvation guard; MEM_ARB_RR_EN selects round-robin.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   idle_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
  output logic   gnt_i_o,
  output logic   gnt_d_o,
  output owner_t owner_o
);

  logic gnt_i, gnt_d;

`ifdef MEM_ARB_RR_EN
  owner_t last_q;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (idle_i) begin
      if (i_req_i && d_req_i) begin
        if (last_q == OWN_D) gnt_i = 1'b1;
        else                 gnt_d = 1'b1;
      end else begin
        gnt_i = i_req_i;
        gnt_d = d_req_i;
      end
    end
  end

  // Starts at OWN_I so the first conflict after reset goes to D.
  always_ff @(posedge clk_i) begin
    if (rst_i)      last_q <= OWN_I;
    else if (gnt_i) last_q <= OWN_I;
    else if (gnt_d) last_q <= OWN_D;
  end
`else
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (idle_i) begin
      if (i_req_i && d_req_i) begin
        if (starve_q == STARVE_LIM) gnt_i = 1'b1;
        else                        gnt_d = 1'b1;
      end else begin
        gnt_i = i_req_i;
        gnt_d = d_req_i;
      end
    end
  end

  // Counts conflicts I lost back-to-back; only moves while the arbiter is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (idle_i) begin
      if (gnt_i || !i_req_i)
        starve_q <= '0;
      else if (gnt_d && starve_q != STARVE_LIM)
        starve_q <= starve_q + 1'b1;
    end
  end
`endif

  assign gnt_i_o = gnt_i;
  assign gnt_d_o = gnt_d;
  assign owner_o = gnt_d ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory between fetch and load/store ports.
// Optional macro MEM_ARB_RR_EN switches the conflict policy to round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 64,
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic          i_gnt_o,
  output logic          i_rvalid_o,
  output logic [DW-1:0] i_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_t        state_q;
  owner_t        owner_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic          m_req_q, m_we_q, busy_q;
  logic          i_rvalid_q, d_rvalid_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q, i_rdata_q, d_rdata_q;

  logic   gnt_i, gnt_d;
  owner_t gnt_owner;

  mem_arb_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .idle_i (state_q == ARB_IDLE),
    .i_req_i(i_req_i),
    .d_req_i(d_req_i),
    .gnt_i_o(gnt_i),
    .gnt_d_o(gnt_d),
    .owner_o(gnt_owner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_I;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (gnt_i || gnt_d) begin
            state_q  <= ARB_ISSUE;
            busy_q   <= 1'b1;
            owner_q  <= gnt_owner;
            m_req_q  <= 1'b1;
            m_we_q   <= gnt_d & d_we_i;
            we_q     <= gnt_d & d_we_i;
            m_addr_q <= gnt_d ? d_addr_i : i_addr_i;
            if (gnt_d) m_wdata_q <= d_wdata_i;
          end
        end
        ARB_ISSUE: begin
          state_q <= ARB_WAIT;
          cnt_q   <= '0;
        end
        ARB_WAIT: begin
          // Memory data is valid in the cycle the counter hits its last value.
          if (cnt_q == CNT_LAST) begin
            state_q <= ARB_RESP;
            if (owner_q == OWN_D) begin
              d_rvalid_q <= 1'b1;
              if (!we_q) d_rdata_q <= m_rdata_i;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= m_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt_o    = gnt_i;
  assign d_gnt_o    = gnt_d;
  assign i_rvalid_o = i_rvalid_q;
  assign i_rdata_o  = i_rdata_q;
  assign d_rvalid_o = d_rvalid_q;
  assign d_rdata_o  = d_rdata_q;
  assign m_req_o    = m_req_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign busy_o     = busy_q;

endmodule
